// File: rtl/mem_pkg.sv
// Shared types for the DRAM sequencing controller.
// Size/state encodings and byte-lane mask constants.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_RSV
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LD_RSP,
    WR,
    RMW_RD,
    RMW_WR,
    ST_RSP,
    ERR
  } state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/dram_ctrl_if.sv
// Core-side request/response bundle of dram_ctrl.
// master = load/store stage, slave = controller.
interface dram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_size, req_unsigned, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_size, req_unsigned, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dram_lane_align.sv
// Byte-lane steering: load extraction/extension,
// store merge into read word, and lane write mask.
// in : size, off, uns, wdata, rword
// out: ldata (extended load), mdata (merged), mask
module dram_lane_align
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] ldata,
  output logic [31:0] mdata,
  output logic [3:0]  mask
);

  logic [31:0] sh;
  logic [31:0] wrep;

  always_comb begin
    sh    = rword >> {off, 3'b000};
    ldata = sh;
    mask  = MASK_W;
    wrep  = wdata;
    unique case (size)
      SZ_B: begin
        ldata = {{24{sh[7] & ~uns}}, sh[7:0]};
        mask  = MASK_B << off;
        wrep  = {4{wdata[7:0]}};
      end
      SZ_H: begin
        ldata = {{16{sh[15] & ~uns}}, sh[15:0]};
        mask  = MASK_H << off;
        wrep  = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    // store data is replicated to every lane,
    // so the mask alone picks the target bytes
    mdata = rword;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) mdata[8*k +: 8] = wrep[8*k +: 8];
    end
  end

endmodule

// File: rtl/dram_ctrl.sv
// Load/store sequencer for a word-wide sync-read DRAM.
// Ports: clk, rst, bus (slave), dram_a/we/din out, dram_spo in.
module dram_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  dram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] dram_a,
  output logic [3:0]        dram_we,
  output logic [31:0]       dram_din,
  input  logic [31:0]       dram_spo
);

  localparam logic [31:0] HI_MASK =
    ~((32'd1 << (ADDR_W + 2)) - 32'd1);

  state_e state, state_n;

  logic [ADDR_W-1:0] wa_q;
  logic [1:0]        off_q;
  size_e             size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;

  size_e       req_sz;
  logic        accept;
  logic        bad;
  logic [31:0] ldata;
  logic [31:0] mdata;
  logic [3:0]  mask;

  assign req_sz = size_e'(bus.req_size);
  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    bad = 1'b0;
    unique case (req_sz)
      SZ_B:   bad = 1'b0;
      SZ_H:   bad = bus.req_addr[0];
      SZ_W:   bad = |bus.req_addr[1:0];
      SZ_RSV: bad = 1'b1;
    endcase
    if (CHECK_RANGE && |(bus.req_addr & HI_MASK))
      bad = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wa_q    <= '0;
      off_q   <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      wa_q    <= bus.req_addr[ADDR_W+1:2];
      off_q   <= bus.req_addr[1:0];
      size_q  <= req_sz;
      uns_q   <= bus.req_unsigned;
      wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (bad)                 state_n = ERR;
          else if (!bus.req_we)    state_n = RD;
          else if (req_sz == SZ_W) state_n = WR;
          else                     state_n = RMW_RD;
        end
      end
      RD:      state_n = LD_RSP;
      LD_RSP:  state_n = IDLE;
      WR:      state_n = ST_RSP;
      RMW_RD:  state_n = RMW_WR;
      RMW_WR:  state_n = ST_RSP;
      ST_RSP:  state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  dram_lane_align u_align (
    .size  (size_q),
    .off   (off_q),
    .uns   (uns_q),
    .wdata (wdata_q),
    .rword (dram_spo),
    .ldata (ldata),
    .mdata (mdata),
    .mask  (mask)
  );

  // dram_a follows the latch, so it holds in IDLE
  assign dram_a        = wa_q;
  assign bus.req_ready = (state == IDLE);

  always_comb begin
    dram_we       = 4'h0;
    dram_din      = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    unique case (state)
      LD_RSP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = ldata;
      end
      WR: begin
        dram_din = wdata_q;
        dram_we  = MASK_W;
      end
      RMW_WR: begin
        dram_din = mdata;
        dram_we  = mask;
      end
      ST_RSP: bus.rsp_valid = 1'b1;
      ERR: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Testbench for dram_ctrl: directed table plus
// random traffic against a byte-addressed model.
module tb_dram_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] dram_a;
  logic [3:0]  dram_we;
  logic [31:0] dram_din;
  logic [31:0] dram_spo;

  dram_ctrl_if bus ();

  dram_ctrl #(.ADDR_W(16), .CHECK_RANGE(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dram_a   (dram_a),
    .dram_we  (dram_we),
    .dram_din (dram_din),
    .dram_spo (dram_spo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    dram_spo <= mem[dram_a];
    if (|dram_we) mem[dram_a] <= dram_din;
  end

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  int errors;
  int checks;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // reference: byte-addressed memory
  logic [7:0] rm [int unsigned];

  function automatic logic [7:0] rb(input int unsigned a);
    return rm.exists(a) ? rm[a] : 8'h00;
  endfunction

  task automatic model(input logic we,
                       input logic [31:0] addr,
                       input logic [1:0] size,
                       input logic uns,
                       input logic [31:0] wd,
                       output logic [31:0] rd,
                       output logic err,
                       output int lat);
    int n;
    logic [31:0] v;
    n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    err = (size == 3) || ((addr % n) != 0) ||
          (addr >= 32'h0004_0000);
    rd = 0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < n; i++)
        rm[addr + i] = wd[8*i +: 8];
      lat = (n == 4) ? 2 : 3;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++)
        v = v | (32'(rb(addr + i)) << (8 * i));
      if (!uns && n < 4 && v[8*n-1])
        v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
      lat = 2;
    end
  endtask

  // per-transaction observations
  logic [31:0] o_rd;
  logic        o_err;
  int          o_lat;
  bit          o_we_seen;
  bit          o_busy_ok;
  int          o_acc;
  logic [15:0] o_a1;
  logic [3:0]  o_w1, o_w2;
  logic [31:0] o_d1, o_d2;

  // call at a negedge; returns at negedge of rsp cycle
  task automatic xact(input logic we,
                      input logic [31:0] addr,
                      input logic [1:0] size,
                      input logic uns,
                      input logic [31:0] wd,
                      input bit hold);
    int n;
    n = 0;
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    o_acc = cyc;
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
    o_lat = 0;
    o_rd = 0;
    o_err = 0;
    o_we_seen = 0;
    o_busy_ok = 1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) begin
        o_a1 = dram_a; o_w1 = dram_we; o_d1 = dram_din;
      end
      if (k == 2) begin
        o_w2 = dram_we; o_d2 = dram_din;
      end
      if (|dram_we) o_we_seen = 1;
      if (bus.req_ready) o_busy_ok = 0;
      if (bus.rsp_valid) begin
        o_lat = k;
        o_rd = bus.rsp_rdata;
        o_err = bus.rsp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_chk(input string nm,
                         input logic we,
                         input logic [31:0] addr,
                         input logic [1:0] size,
                         input logic uns,
                         input logic [31:0] wd,
                         input bit hold);
    logic [31:0] e_rd;
    logic e_err;
    int e_lat;
    model(we, addr, size, uns, wd, e_rd, e_err, e_lat);
    xact(we, addr, size, uns, wd, hold);
    chk({nm, "_rdata"}, o_rd, e_rd);
    chk({nm, "_err"}, 32'(o_err), 32'(e_err));
    chk({nm, "_lat"}, o_lat, e_lat);
    if (e_err) chk({nm, "_no_we"}, 32'(o_we_seen), 0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] m_rd;
    logic        m_err;
    int          m_lat;
    int          prev_acc;
    int          prev_lat;
    int          gap_ok;
    bit          rsp_seen;

    errors = 0;
    checks = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 0;

    vecs[0]  = '{0, 32'h103, 0, 0, 0, 32'hFFFF_FFAA, 0, 2};
    vecs[1]  = '{0, 32'h103, 0, 1, 0, 32'h0000_00AA, 0, 2};
    vecs[2]  = '{1, 32'h102, 1, 0, 32'h1234,
                 32'h0, 0, 3};
    vecs[3]  = '{0, 32'h102, 1, 0, 0, 32'h0000_1234, 0, 2};
    vecs[4]  = '{0, 32'h100, 2, 0, 0, 32'h1234_BEEF, 0, 2};
    vecs[5]  = '{1, 32'h100, 1, 0, 32'h8001,
                 32'h0, 0, 3};
    vecs[6]  = '{0, 32'h100, 1, 0, 0, 32'hFFFF_8001, 0, 2};
    vecs[7]  = '{0, 32'h102, 2, 0, 0, 32'h0, 1, 1};
    vecs[8]  = '{1, 32'h101, 1, 0, 32'h5A5A, 32'h0, 1, 1};
    vecs[9]  = '{0, 32'h100, 3, 0, 0, 32'h0, 1, 1};
    vecs[10] = '{0, 32'h0004_0000, 2, 0, 0, 32'h0, 1, 1};

    bus.req_valid    = 0;
    bus.req_we       = 0;
    bus.req_addr     = 0;
    bus.req_size     = 0;
    bus.req_unsigned = 0;
    bus.req_wdata    = 0;
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_dram_a", 32'(dram_a), 0);
    chk("rst_dram_we", 32'(dram_we), 0);
    chk("rst_dram_din", dram_din, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // word store: WR in T+1, rsp in T+2
    model(1, 32'h100, 2, 0, 32'hDEAD_BEEF, m_rd, m_err, m_lat);
    xact(1, 32'h100, 2, 0, 32'hDEAD_BEEF, 0);
    chk("wst_a", 32'(o_a1), 32'h40);
    chk("wst_we", 32'(o_w1), 32'hF);
    chk("wst_din", o_d1, 32'hDEAD_BEEF);
    chk("wst_lat", o_lat, 2);
    chk("wst_err", 32'(o_err), 0);

    // byte store: merged word in RMW_WR at T+2
    model(1, 32'h103, 0, 0, 32'hAA, m_rd, m_err, m_lat);
    xact(1, 32'h103, 0, 0, 32'hAA, 0);
    chk("bst_we1", 32'(o_w1), 0);
    chk("bst_we2", 32'(o_w2), 32'h8);
    chk("bst_din", o_d2, 32'hAAAD_BEEF);
    chk("bst_lat", o_lat, 3);

    for (int i = 0; i < 11; i++) begin
      model(vecs[i].we, vecs[i].addr, vecs[i].size,
            vecs[i].uns, vecs[i].wd, m_rd, m_err, m_lat);
      xact(vecs[i].we, vecs[i].addr, vecs[i].size,
           vecs[i].uns, vecs[i].wd, 0);
      chk($sformatf("vec%0d_rdata", i), o_rd, vecs[i].e_rd);
      chk($sformatf("vec%0d_err", i),
          32'(o_err), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d_lat", i), o_lat, vecs[i].e_lat);
      if (vecs[i].e_err)
        chk($sformatf("vec%0d_no_we", i),
            32'(o_we_seen), 0);
    end

    // back-to-back with req_valid held high
    @(negedge clk);
    prev_acc = -1;
    prev_lat = 0;
    for (int i = 0; i < 5; i++) begin
      logic        b_we;
      logic [31:0] b_ad;
      logic [1:0]  b_sz;
      logic [31:0] b_wd;
      unique case (i)
        0: begin b_we = 0; b_ad = 32'h100; b_sz = 2; end
        1: begin b_we = 1; b_ad = 32'h101; b_sz = 0; end
        2: begin b_we = 1; b_ad = 32'h104; b_sz = 2; end
        3: begin b_we = 0; b_ad = 32'h100; b_sz = 2; end
        default: begin b_we = 0; b_ad = 32'h102; b_sz = 2; end
      endcase
      b_wd = 32'h0BAD_F077 + i;
      run_chk($sformatf("b2b%0d", i),
              b_we, b_ad, b_sz, 0, b_wd, 1);
      chk($sformatf("b2b%0d_busy", i), 32'(o_busy_ok), 1);
      if (prev_acc >= 0)
        chk($sformatf("b2b%0d_gap", i),
            o_acc - prev_acc, prev_lat + 1);
      prev_acc = o_acc;
      prev_lat = o_lat;
    end
    bus.req_valid = 0;
    @(negedge clk);

    // reset during RMW_WR discards the write
    bus.req_we = 1;
    bus.req_addr = 32'h100;
    bus.req_size = 0;
    bus.req_unsigned = 0;
    bus.req_wdata = 32'h55;
    bus.req_valid = 1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    @(negedge clk);
    chk("abort_we_pre", 32'(dram_we), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("abort_we", 32'(dram_we), 0);
    chk("abort_din", dram_din, 0);
    chk("abort_a", 32'(dram_a), 0);
    chk("abort_ready", 32'(bus.req_ready), 1);
    rsp_seen = 0;
    @(negedge clk);
    if (bus.rsp_valid) rsp_seen = 1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen = 1;
    end
    chk("abort_no_rsp", 32'(rsp_seen), 0);
    run_chk("abort_reload", 0, 32'h100, 2, 0, 0, 0);

    // random traffic against the model
    gap_ok = 0;
    for (int i = 0; i < 200; i++) begin
      logic        r_we;
      logic [31:0] r_ad;
      logic [1:0]  r_sz;
      logic        r_un;
      logic [31:0] r_wd;
      r_we = 1'($urandom_range(0, 1));
      r_ad = 32'h200 + $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0)
        r_ad = r_ad | (32'($urandom_range(1, 255)) << 18);
      r_sz = 2'($urandom_range(0, 3));
      r_un = 1'($urandom_range(0, 1));
      r_wd = $urandom;
      run_chk($sformatf("rnd%0d", i), r_we, r_ad, r_sz,
              r_un, r_wd, 1'($urandom_range(0, 1)));
    end
    bus.req_valid = 0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
